game_sprite_layer: RTL and testbench
====================================

// Module: game_sprite_layer
// PURPOSE
// Parametrised sprite compositor stage for the game pipeline, inserted between vga_if stages.
// Overlays N_SPR independent sprites (player, enemies, items) onto the incoming picture, with per-sprite enable, mirror and priority.
// Drives one registered-ROM address port per sprite.
// Reports sprite-to-sprite collisions once per frame to game logic.
// Generalises the single-sprite draw stage: N channels, frame-synchronous position latching, collision output.
// PARAMETERS
// N_SPR    4        number of sprite channels; index 0 = highest priority
// SPR_W    48       sprite width in pixels
// SPR_H    64       sprite height in pixels
// ADDR_W   16       ROM address width; must satisfy SPR_W*SPR_H <= 2**ADDR_W
// ROM_LAT  1        sprite ROM read latency in clk cycles (>=1)
// KEY_RGB  12'hF0F  transparent colour key
// PORTS
// clk         in   1            pixel clock
// rst         in   1            reset
// in          in   vga_if.in    vcount/vsync/vblnk/hcount/hsync/hblnk/rgb[11:0]
// out         out  vga_if.out   same fields, delayed by L = ROM_LAT+2 cycles
// spr_en      in   N_SPR        sprite i visible
// spr_mirror  in   N_SPR        sprite i drawn horizontally flipped
// spr_x       in   N_SPR*11     left edge of sprite i, screen pixels
// spr_y       in   N_SPR*10     top edge of sprite i, screen lines
// spr_addr    out  N_SPR*ADDR_W ROM address for sprite i
// spr_rgb     in   N_SPR*12     ROM data for sprite i, valid ROM_LAT cycles after spr_addr
// coll_flags  out  N_SPR        bit i = sprite i overlapped another opaque sprite in last frame
// frame_done  out  1            one-cycle pulse; coll_flags updated on this cycle
// BEHAVIOUR
// Clocking and reset
// - One clock; reset is asynchronous and active-high.
// - Reset clears all out fields, spr_addr, coll_flags, frame_done, latched positions/enables and the collision accumulator.
// Frame latch
// - A frame edge is the in.vblnk 0->1 transition, detected with a 1-cycle delayed copy of in.vblnk.
// - On a frame edge, spr_en/spr_mirror/spr_x/spr_y are copied into shadow registers.
// - Only shadow values are used for drawing, so a mid-frame position change takes effect next frame (no tearing).
// Stage 1 (cycle 0 -> 1)
// - For each sprite, hit = shadow_en && hcount in [x, x+SPR_W) && vcount in [y, y+SPR_H).
// - Compare in 12 bits so x+SPR_W never wraps.
// - col = hcount-x, or SPR_W-1-(hcount-x) when mirrored; row = vcount-y.
// - spr_addr = row*SPR_W + col, registered; forced to 0 when hit=0 or when in.hblnk|in.vblnk.
// - Delay the hit bits and all vga fields alongside.
// Stage 2 (ROM_LAT cycles)
// - Delay hit bits and vga fields to align with spr_rgb.
// Stage 3 (registered output)
// - opaque_i = hit_i && spr_rgb_i != KEY_RGB.
// - out.rgb = spr_rgb of the lowest-index opaque sprite, else the delayed in.rgb.
// - During blanking, out.rgb = delayed in.rgb and no sprite is drawn.
// - out timing fields = in delayed by exactly L cycles.
// Collision accumulator
// - When >=2 opaque bits are set on a pixel, OR every opaque bit into acc.
// - On the frame edge: coll_flags <= acc, acc <= 0, frame_done = 1 for that cycle.
// - The pipeline holds only blanked pixels at the frame edge (vblnk starts a whole blank line), so no active pixel is lost or counted twice.
// - Exception: the first frame edge after reset only loads the shadow registers; frame_done stays 0 and coll_flags stay 0.
// Boundaries
// - Sprites partially off-screen are clipped naturally; positions beyond the visible range draw nothing.
// - Two sprites with identical position and data: the lower index is drawn, and both flags are set if the pixels are opaque.
// - An all-transparent sprite never collides.
// - Reset asserted mid-frame: outputs 0 immediately; drawing resumes after the next frame edge.
// TESTING
// 1. Pipeline latency: N_SPR=4, all spr_en=0, ramp in.rgb -> out equals in delayed by L=3 cycles for every field, frame_done pulses each frame after the first.
// 2. Single sprite: x=100, y=50, solid 12'h0F0 ROM -> out.rgb=0F0 exactly for hcount 100..147, vcount 50..113; background elsewhere; spr_addr=0 at (100,50) and 3071 at (147,113).
// 3. Mirror: spr_mirror[0]=1, ROM = address-coded -> spr_addr at (100,50) is 47 and at (147,50) is 0.
// 4. Priority and key: sprites 0 and 1 overlapping, sprite 0 pixel = KEY_RGB -> sprite 1 colour shown; sprite 0 opaque -> sprite 0 shown; coll_flags=4'b0011 after frame_done.
// 5. Tear-free latch: change spr_x from 100 to 200 mid-frame -> current frame still drawn at 100; next frame drawn at 200.
// 6. Reset mid-frame: assert rst for 3 cycles on line 300 -> outputs 0; first frame edge gives no frame_done; second frame edge gives correct coll_flags.

Source files
------------

// File: rtl/game_sprite_layer_if.sv
// Raster bundle passed between video pipeline stages: timing fields plus 12-bit colour.
// The producer uses the master modport and the consumer uses the slave modport.
interface game_sprite_layer_if;
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;

    modport master (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
    modport slave  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/game_sprite_layer.sv
// Multi-sprite compositor stage: overlays N_SPR ROM-backed sprites onto the raster,
// with frame-latched positions, priority by index, colour keying and per-frame collision flags.
module game_sprite_layer #(
    parameter int          N_SPR   = 4,
    parameter int          SPR_W   = 48,
    parameter int          SPR_H   = 64,
    parameter int          ADDR_W  = 16,
    parameter int          ROM_LAT = 1,
    parameter logic [11:0] KEY_RGB = 12'hF0F
) (
    input  logic                      clk,
    input  logic                      rst,
    game_sprite_layer_if.slave        in,
    game_sprite_layer_if.master       out,
    input  logic [N_SPR-1:0]          spr_en,
    input  logic [N_SPR-1:0]          spr_mirror,
    input  logic [N_SPR*11-1:0]       spr_x,
    input  logic [N_SPR*10-1:0]       spr_y,
    output logic [N_SPR*ADDR_W-1:0]   spr_addr,
    input  logic [N_SPR*12-1:0]       spr_rgb,
    output logic [N_SPR-1:0]          coll_flags,
    output logic                      frame_done
);

    typedef struct packed {
        logic [10:0] vcount;
        logic        vsync;
        logic        vblnk;
        logic [10:0] hcount;
        logic        hsync;
        logic        hblnk;
        logic [11:0] rgb;
    } vga_t;

    localparam logic [ADDR_W-1:0] W_A  = ADDR_W'(SPR_W);
    localparam logic [ADDR_W-1:0] W_M1 = ADDR_W'(SPR_W - 1);
    localparam logic [11:0]       W_12 = 12'(SPR_W);
    localparam logic [11:0]       H_12 = 12'(SPR_H);

    vga_t              vga_in;
    logic              blank;
    logic              frame_edge;
    logic              vblnk_d_reg;
    logic              armed_reg;

    logic [N_SPR-1:0]    sh_en_reg;
    logic [N_SPR-1:0]    sh_mir_reg;
    logic [N_SPR*11-1:0] sh_x_reg;
    logic [N_SPR*10-1:0] sh_y_reg;

    logic [N_SPR-1:0]  hit_s0;
    logic [ADDR_W-1:0] addr_s0 [N_SPR];

    logic [N_SPR*ADDR_W-1:0] spr_addr_reg;
    vga_t                    vga_pipe_reg [ROM_LAT+1];
    logic [N_SPR-1:0]        hit_pipe_reg [ROM_LAT+1];

    logic [N_SPR-1:0]  opaque;
    logic [11:0]       pix_rgb;
    logic              multi_hit;
    vga_t              out_next;
    vga_t              out_reg;

    logic [N_SPR-1:0]  acc_reg;
    logic [N_SPR-1:0]  coll_flags_reg;
    logic              frame_done_reg;

    assign vga_in     = {in.vcount, in.vsync, in.vblnk, in.hcount, in.hsync, in.hblnk, in.rgb};
    assign blank      = in.hblnk | in.vblnk;
    assign frame_edge = in.vblnk & ~vblnk_d_reg;

    // Per-sprite hit test and ROM address, all against the frame-latched shadow copy.
    for (genvar gi = 0; gi < N_SPR; gi++) begin : g_lane
        logic [11:0]       x12, y12, h12, v12;
        logic [ADDR_W-1:0] col, row, col_m;

        assign x12 = {1'b0, sh_x_reg[gi*11 +: 11]};
        assign y12 = {2'b0, sh_y_reg[gi*10 +: 10]};
        assign h12 = {1'b0, in.hcount};
        assign v12 = {1'b0, in.vcount};

        assign hit_s0[gi] = sh_en_reg[gi] && !blank &&
                            (h12 >= x12) && (h12 < x12 + W_12) &&
                            (v12 >= y12) && (v12 < y12 + H_12);

        assign col   = ADDR_W'(h12 - x12);
        assign row   = ADDR_W'(v12 - y12);
        assign col_m = sh_mir_reg[gi] ? (W_M1 - col) : col;

        assign addr_s0[gi] = hit_s0[gi] ? (row * W_A + col_m) : '0;
    end

    // Address register plus hit/raster delay line that lines up with ROM data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spr_addr_reg <= '0;
            for (int k = 0; k <= ROM_LAT; k++) begin
                vga_pipe_reg[k] <= '0;
                hit_pipe_reg[k] <= '0;
            end
        end else begin
            for (int i = 0; i < N_SPR; i++) begin
                spr_addr_reg[i*ADDR_W +: ADDR_W] <= addr_s0[i];
            end
            vga_pipe_reg[0] <= vga_in;
            hit_pipe_reg[0] <= hit_s0;
            for (int k = 1; k <= ROM_LAT; k++) begin
                vga_pipe_reg[k] <= vga_pipe_reg[k-1];
                hit_pipe_reg[k] <= hit_pipe_reg[k-1];
            end
        end
    end

    // Walk from lowest priority upward so the lowest opaque index wins.
    always_comb begin
        opaque  = '0;
        pix_rgb = vga_pipe_reg[ROM_LAT].rgb;
        for (int i = N_SPR - 1; i >= 0; i--) begin
            if (hit_pipe_reg[ROM_LAT][i] && (spr_rgb[i*12 +: 12] != KEY_RGB)) begin
                opaque[i] = 1'b1;
                pix_rgb   = spr_rgb[i*12 +: 12];
            end
        end
        out_next     = vga_pipe_reg[ROM_LAT];
        out_next.rgb = pix_rgb;
    end

    assign multi_hit = |(opaque & (opaque - N_SPR'(1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_reg        <= '0;
            vblnk_d_reg    <= 1'b0;
            armed_reg      <= 1'b0;
            sh_en_reg      <= '0;
            sh_mir_reg     <= '0;
            sh_x_reg       <= '0;
            sh_y_reg       <= '0;
            acc_reg        <= '0;
            coll_flags_reg <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            out_reg        <= out_next;
            vblnk_d_reg    <= in.vblnk;
            frame_done_reg <= 1'b0;
            if (frame_edge) begin
                sh_en_reg  <= spr_en;
                sh_mir_reg <= spr_mirror;
                sh_x_reg   <= spr_x;
                sh_y_reg   <= spr_y;
                armed_reg  <= 1'b1;
                acc_reg    <= '0;
                // The edge right after reset only primes the shadows.
                if (armed_reg) begin
                    coll_flags_reg <= acc_reg;
                    frame_done_reg <= 1'b1;
                end
            end else if (multi_hit) begin
                acc_reg <= acc_reg | opaque;
            end
        end
    end

    assign out.vcount = out_reg.vcount;
    assign out.vsync  = out_reg.vsync;
    assign out.vblnk  = out_reg.vblnk;
    assign out.hcount = out_reg.hcount;
    assign out.hsync  = out_reg.hsync;
    assign out.hblnk  = out_reg.hblnk;
    assign out.rgb    = out_reg.rgb;

    assign spr_addr   = spr_addr_reg;
    assign coll_flags = coll_flags_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_game_sprite_layer.sv
// Bench for game_sprite_layer: directed probe table, hand-written frame/reset sequences,
// and randomized raster traffic checked against an arithmetic sprite model.
module tb_game_sprite_layer;

    localparam int          N   = 4;
    localparam int          W   = 48;
    localparam int          H   = 64;
    localparam int          AW  = 16;
    localparam int          LAT = 1;
    localparam logic [11:0] KEY = 12'hF0F;

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
        logic [11:0] rgb;
    } pix_t;

    typedef struct {
        int          phase;
        int          h;
        int          v;
        logic        hb;
        logic [11:0] bg;
        logic [AW-1:0] exp_a0;
        logic [11:0] exp_rgb;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    game_sprite_layer_if vin ();
    game_sprite_layer_if vout ();

    logic [N-1:0]    spr_en, spr_mirror;
    logic [N*11-1:0] spr_x;
    logic [N*10-1:0] spr_y;
    logic [N*AW-1:0] spr_addr;
    logic [N*12-1:0] spr_rgb;
    logic [N-1:0]    coll_flags;
    logic            frame_done;

    game_sprite_layer #(
        .N_SPR(N), .SPR_W(W), .SPR_H(H), .ADDR_W(AW), .ROM_LAT(LAT), .KEY_RGB(KEY)
    ) dut (
        .clk(clk), .rst(rst), .in(vin), .out(vout),
        .spr_en(spr_en), .spr_mirror(spr_mirror), .spr_x(spr_x), .spr_y(spr_y),
        .spr_addr(spr_addr), .spr_rgb(spr_rgb),
        .coll_flags(coll_flags), .frame_done(frame_done)
    );

    // Sprite control as the game logic sees it.
    logic        en_v  [N];
    logic        mir_v [N];
    int          x_v   [N];
    int          y_v   [N];
    int          rom_mode [N];
    logic [11:0] rom_col  [N];

    always_comb begin
        spr_en     = '0;
        spr_mirror = '0;
        spr_x      = '0;
        spr_y      = '0;
        for (int i = 0; i < N; i++) begin
            spr_en[i]          = en_v[i];
            spr_mirror[i]      = mir_v[i];
            spr_x[i*11 +: 11]  = 11'(x_v[i]);
            spr_y[i*10 +: 10]  = 10'(y_v[i]);
        end
    end

    // Sprite image content: 0 solid, 1 address-coded, 2 hashed with holes, 3 top row keyed, else all key.
    function automatic logic [11:0] rom_f(int i, int a);
        case (rom_mode[i])
            0:       return rom_col[i];
            1:       return 12'(a);
            2:       return (((a * 37 + i * 101) % 5) == 0) ? KEY : 12'(a * 29 + i * 7 + 1);
            3:       return (a < W) ? KEY : 12'hF00;
            default: return KEY;
        endcase
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            spr_rgb[i*12 +: 12] <= rom_f(i, int'(spr_addr[i*AW +: AW]));
        end
    end

    // Reference model state.
    logic        sh_en  [N];
    logic        sh_mir [N];
    int          sh_x   [N];
    int          sh_y   [N];
    logic        armed;
    logic        prev_vb;
    logic [N-1:0] acc;
    logic [N-1:0] cur_coll;

    pix_t            oq [$];
    logic [N*AW-1:0] aq [$];
    logic [N:0]      fq [$];

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic pix_t mk(int h, int v, logic hb, logic vb, logic [11:0] rgb, logic hs, logic vs);
        pix_t p;
        p.h = 11'(h); p.v = 11'(v); p.hb = hb; p.vb = vb; p.rgb = rgb; p.hs = hs; p.vs = vs;
        return p;
    endfunction

    function automatic pix_t blank_pix();
        return mk(600, 0, 1'b1, 1'b0, 12'($urandom), 1'b1, 1'b0);
    endfunction

    task automatic model_pix(input pix_t p, output logic [11:0] rgb,
                             output logic [N*AW-1:0] addrs, output logic [N-1:0] opq);
        int h, v, col, row, a;
        logic [11:0] c;
        logic found;
        h = int'(p.h); v = int'(p.v);
        rgb = p.rgb; addrs = '0; opq = '0; found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (sh_en[i] && !p.hb && !p.vb &&
                h >= sh_x[i] && h < sh_x[i] + W && v >= sh_y[i] && v < sh_y[i] + H) begin
                col = h - sh_x[i];
                if (sh_mir[i]) col = W - 1 - col;
                row = v - sh_y[i];
                a = row * W + col;
                addrs[i*AW +: AW] = AW'(a);
                c = rom_f(i, a);
                if (c != KEY) begin
                    opq[i] = 1'b1;
                    if (!found) begin
                        rgb = c;
                        found = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic drive(input pix_t p);
        pix_t pe;
        logic [11:0] rgb;
        logic [N*AW-1:0] addrs;
        logic [N-1:0] opq;
        logic fd;
        vin.hcount = p.h; vin.vcount = p.v; vin.hsync = p.hs; vin.vsync = p.vs;
        vin.hblnk = p.hb; vin.vblnk = p.vb; vin.rgb = p.rgb;
        fd = 1'b0;
        if (p.vb && !prev_vb) begin
            if (armed) begin
                cur_coll = acc;
                fd = 1'b1;
            end
            armed = 1'b1;
            acc = '0;
            for (int i = 0; i < N; i++) begin
                sh_en[i] = en_v[i]; sh_mir[i] = mir_v[i];
                sh_x[i] = x_v[i] % 2048; sh_y[i] = y_v[i] % 1024;
            end
        end
        prev_vb = p.vb;
        model_pix(p, rgb, addrs, opq);
        if ($countones(opq) >= 2) acc = acc | opq;
        pe = p;
        pe.rgb = rgb;
        oq.push_back(pe);
        aq.push_back(addrs);
        fq.push_back({fd, cur_coll});
    endtask

    task automatic step(input pix_t p);
        pix_t eo;
        logic [N*AW-1:0] ea;
        logic [N:0] ef;
        @(posedge clk);
        #1;
        eo = oq.pop_front();
        ea = aq.pop_front();
        ef = fq.pop_front();
        chk("out_fields", {vout.hcount, vout.vcount, vout.hsync, vout.vsync,
                           vout.hblnk, vout.vblnk, vout.rgb}, eo);
        chk("spr_addr", spr_addr, ea);
        chk("frame_done_coll", {frame_done, coll_flags}, ef);
        drive(p);
    endtask

    task automatic do_reset();
        pix_t z;
        @(posedge clk);
        #1;
        rst = 1'b1;
        z = blank_pix();
        vin.hcount = z.h; vin.vcount = z.v; vin.hsync = z.hs; vin.vsync = z.vs;
        vin.hblnk = z.hb; vin.vblnk = z.vb; vin.rgb = z.rgb;
        armed = 1'b0; prev_vb = 1'b0; acc = '0; cur_coll = '0;
        for (int i = 0; i < N; i++) begin
            sh_en[i] = 1'b0; sh_mir[i] = 1'b0; sh_x[i] = 0; sh_y[i] = 0;
        end
        #1;
        chk("rst_async_out", {vout.hcount, vout.vcount, vout.rgb, vout.hblnk, vout.vblnk}, 64'd0);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("rst_out", {vout.hcount, vout.vcount, vout.hsync, vout.vsync,
                            vout.hblnk, vout.vblnk, vout.rgb}, 64'd0);
            chk("rst_addr", spr_addr, 64'd0);
            chk("rst_fd_coll", {frame_done, coll_flags}, 64'd0);
        end
        rst = 1'b0;
        oq.delete(); aq.delete(); fq.delete();
        oq.push_back('0);
        oq.push_back('0);
        drive(z);
        $display("reset: 3 cycles, outputs held at zero");
    endtask

    task automatic frame_edge(output logic fd, output logic [N-1:0] cf);
        repeat (4) step(blank_pix());
        step(mk(0, 480, 1'b1, 1'b1, 12'h000, 1'b0, 1'b1));
        step(mk(1, 480, 1'b1, 1'b1, 12'h000, 1'b0, 1'b1));
        fd = frame_done;
        cf = coll_flags;
        step(blank_pix());
        $display("frame edge: frame_done=%0b coll_flags=%04b", fd, cf);
    endtask

    task automatic probe(input string nm, input int h, input int v, input logic hb,
                         input logic [11:0] bg, input logic [AW-1:0] ea, input logic [11:0] er);
        logic [AW-1:0] ga;
        logic [11:0]   gr;
        step(mk(h, v, hb, 1'b0, bg, 1'b0, 1'b0));
        step(blank_pix());
        ga = spr_addr[AW-1:0];
        chk({nm, "_addr0"}, 64'(ga), 64'(ea));
        step(blank_pix());
        step(blank_pix());
        gr = vout.rgb;
        chk({nm, "_rgb"}, 64'(gr), 64'(er));
        $display("probe %s (%0d,%0d) hb=%0b: addr0=%0d rgb=%03h", nm, h, v, hb, ga, gr);
    endtask

    task automatic set_spr(input int i, input logic en, input logic mir, input int x, input int y,
                           input int mode, input logic [11:0] col);
        en_v[i] = en; mir_v[i] = mir; x_v[i] = x; y_v[i] = y;
        rom_mode[i] = mode; rom_col[i] = col;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [14];
        logic fd;
        logic [N-1:0] cf;
        int lat, cur;

        tbl[0]  = '{1, 100,  50, 1'b0, 12'h123, 16'd0,    12'h0F0};
        tbl[1]  = '{1, 147, 113, 1'b0, 12'h123, 16'd3071, 12'h0F0};
        tbl[2]  = '{1,  99,  50, 1'b0, 12'h123, 16'd0,    12'h123};
        tbl[3]  = '{1, 148,  50, 1'b0, 12'h124, 16'd0,    12'h124};
        tbl[4]  = '{1, 100,  49, 1'b0, 12'h125, 16'd0,    12'h125};
        tbl[5]  = '{1, 100, 114, 1'b0, 12'h126, 16'd0,    12'h126};
        tbl[6]  = '{1, 147,  50, 1'b0, 12'h127, 16'd47,   12'h0F0};
        tbl[7]  = '{1, 120,  60, 1'b1, 12'h128, 16'd0,    12'h128};
        tbl[8]  = '{2, 100,  50, 1'b0, 12'h321, 16'd47,   12'h02F};
        tbl[9]  = '{2, 147,  50, 1'b0, 12'h321, 16'd0,    12'h000};
        tbl[10] = '{2, 101,  51, 1'b0, 12'h321, 16'd94,   12'h05E};
        tbl[11] = '{3, 110,  50, 1'b0, 12'h555, 16'd10,   12'h00F};
        tbl[12] = '{3, 110,  60, 1'b0, 12'h555, 16'd490,  12'hF00};
        tbl[13] = '{3, 160,  60, 1'b0, 12'h556, 16'd0,    12'h556};

        for (int i = 0; i < N; i++) set_spr(i, 1'b0, 1'b0, 0, 0, 4, 12'h000);
        do_reset();

        // Pass-through with no sprites: ramp on every field, then the latency of a marker pixel.
        for (int k = 0; k < 40; k++) begin
            step(mk(k, 10, 1'b0, 1'b0, 12'(k * 97), k[2], k[4]));
        end
        step(mk(7, 7, 1'b0, 1'b0, 12'hABC, 1'b0, 1'b0));
        lat = 0;
        for (int c = 1; c <= 6; c++) begin
            step(mk(8, 7, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0));
            if (vout.rgb == 12'hABC && lat == 0) lat = c;
        end
        chk("latency", 64'(lat), 64'd3);
        $display("latency: marker pixel emerged after %0d cycles", lat);
        frame_edge(fd, cf);
        chk("first_edge_no_done", 64'(fd), 64'd0);
        for (int k = 0; k < 10; k++) step(mk(k, 20, 1'b0, 1'b0, 12'($urandom), 1'b1, 1'b0));
        frame_edge(fd, cf);
        chk("second_edge_done", 64'(fd), 64'd1);
        chk("second_edge_coll", 64'(cf), 64'd0);

        // Directed probe table: single sprite, mirror, priority/key.
        cur = 0;
        for (int k = 0; k < 14; k++) begin
            if (tbl[k].phase != cur) begin
                cur = tbl[k].phase;
                for (int i = 0; i < N; i++) set_spr(i, 1'b0, 1'b0, 0, 0, 4, 12'h000);
                case (cur)
                    1: set_spr(0, 1'b1, 1'b0, 100, 50, 0, 12'h0F0);
                    2: set_spr(0, 1'b1, 1'b1, 100, 50, 1, 12'h000);
                    default: begin
                        set_spr(0, 1'b1, 1'b0, 100, 50, 3, 12'h000);
                        set_spr(1, 1'b1, 1'b0, 100, 50, 0, 12'h00F);
                        set_spr(2, 1'b1, 1'b0, 100, 50, 4, 12'h000);
                    end
                endcase
                frame_edge(fd, cf);
            end
            probe($sformatf("vec%0d", k), tbl[k].h, tbl[k].v, tbl[k].hb, tbl[k].bg,
                  tbl[k].exp_a0, tbl[k].exp_rgb);
        end
        frame_edge(fd, cf);
        chk("prio_done", 64'(fd), 64'd1);
        chk("prio_coll", 64'(cf), 64'b0011);

        // Tear-free latch: a mid-frame move applies from the next frame.
        for (int i = 0; i < N; i++) set_spr(i, 1'b0, 1'b0, 0, 0, 4, 12'h000);
        set_spr(0, 1'b1, 1'b0, 100, 50, 0, 12'h0F0);
        frame_edge(fd, cf);
        probe("tear_a", 100, 50, 1'b0, 12'h111, 16'd0, 12'h0F0);
        x_v[0] = 200;
        probe("tear_b", 100, 51, 1'b0, 12'h111, 16'd48, 12'h0F0);
        probe("tear_c", 200, 51, 1'b0, 12'h112, 16'd0, 12'h112);
        frame_edge(fd, cf);
        probe("tear_d", 200, 52, 1'b0, 12'h113, 16'd96, 12'h0F0);
        probe("tear_e", 100, 52, 1'b0, 12'h114, 16'd0, 12'h114);

        // Reset on line 300 while two sprites overlap.
        set_spr(0, 1'b1, 1'b0, 100, 280, 0, 12'hF00);
        set_spr(1, 1'b1, 1'b0, 100, 280, 0, 12'h0F0);
        frame_edge(fd, cf);
        probe("rst_pre", 110, 300, 1'b0, 12'h222, 16'd970, 12'hF00);
        do_reset();
        probe("rst_post", 110, 300, 1'b0, 12'h223, 16'd0, 12'h223);
        frame_edge(fd, cf);
        chk("rst_edge1_done", 64'(fd), 64'd0);
        chk("rst_edge1_coll", 64'(cf), 64'd0);
        probe("rst_draw", 110, 300, 1'b0, 12'h224, 16'd970, 12'hF00);
        frame_edge(fd, cf);
        chk("rst_edge2_done", 64'(fd), 64'd1);
        chk("rst_edge2_coll", 64'(cf), 64'b0011);

        // Randomized frames against the model.
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < N; i++) begin
                set_spr(i, 1'($urandom_range(0, 3) != 0), 1'($urandom),
                        ($urandom_range(0, 9) == 0) ? 2000 : int'($urandom_range(0, 300)),
                        ($urandom_range(0, 9) == 0) ? 1000 : int'($urandom_range(0, 220)),
                        int'($urandom_range(0, 4)), 12'($urandom));
            end
            frame_edge(fd, cf);
            for (int k = 0; k < 600; k++) begin
                if ($urandom_range(0, 99) == 0) begin
                    x_v[$urandom_range(0, N - 1)] = int'($urandom_range(0, 300));
                end
                step(mk(int'($urandom_range(0, 330)), int'($urandom_range(0, 280)),
                        1'($urandom_range(0, 7) == 0), 1'b0, 12'($urandom),
                        1'($urandom), 1'($urandom)));
            end
            $display("random frame %0d: 600 pixels, running miscompares %0d", f, miscompares);
        end
        frame_edge(fd, cf);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
